// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus operation encoding, slave FSM states and bus widths.
package i2c_pkg;

    localparam int I2C_ADDR_WIDTH = 7;
    localparam int I2C_DATA_WIDTH = 8;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } i2c_op_t;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } slave_state_t;

endpackage

// File: rtl/i2c_cond_detect.sv
// Brings asynchronous SCL/SDA into the clk domain and flags SCL edges and START/STOP.
// Event outputs are registered, so a pin edge shows up as an event 3 clk later.
module i2c_cond_detect (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o,
    output logic sda_sync_o
);

    // bit 0 = metastability flop, bit 1 = synchronized, bit 2 = history
    logic [2:0] r_scl_pipe;
    logic [2:0] r_sda_pipe;
    logic       r_scl_rise;
    logic       r_scl_fall;
    logic       r_start_det;
    logic       r_stop_det;
    logic       w_scl_high;

    assign w_scl_high = r_scl_pipe[1] & r_scl_pipe[2];

    // Pipes reset to the idle bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_scl_pipe  <= '1;
            r_sda_pipe  <= '1;
            r_scl_rise  <= 1'b0;
            r_scl_fall  <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
        end else begin
            r_scl_pipe  <= {r_scl_pipe[1:0], scl_i};
            r_sda_pipe  <= {r_sda_pipe[1:0], sda_i};
            r_scl_rise  <= r_scl_pipe[1] & ~r_scl_pipe[2];
            r_scl_fall  <= ~r_scl_pipe[1] & r_scl_pipe[2];
            r_start_det <= w_scl_high & ~r_sda_pipe[1] & r_sda_pipe[2];
            r_stop_det  <= w_scl_high & r_sda_pipe[1] & ~r_sda_pipe[2];
        end
    end

    assign scl_rise_o  = r_scl_rise;
    assign scl_fall_o  = r_scl_fall;
    assign start_det_o = r_start_det;
    assign stop_det_o  = r_stop_det;
    assign sda_sync_o  = r_sda_pipe[2];

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing a small register file on the bus (pointer byte, then data bytes)
// plus a host-side port with direct register access.
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter int                    ADDR_WIDTH = I2C_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22,
    parameter int                    DATA_WIDTH = I2C_DATA_WIDTH,
    parameter int                    NUM_REGS   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        sda_o,
    input  logic                        host_we_i,
    input  logic [$clog2(NUM_REGS)-1:0] host_addr_i,
    input  logic [DATA_WIDTH-1:0]       host_wdata_i,
    output logic [DATA_WIDTH-1:0]       host_rdata_o,
    output logic                        busy_o,
    output logic                        start_o,
    output logic                        stop_o,
    output logic                        wr_valid_o,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr_o
);

    localparam int PW = $clog2(NUM_REGS);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start_det;
    logic w_stop_det;
    logic w_sda_sync;

    i2c_cond_detect u_cond (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .scl_i       (scl_i),
        .sda_i       (sda_i),
        .scl_rise_o  (w_scl_rise),
        .scl_fall_o  (w_scl_fall),
        .start_det_o (w_start_det),
        .stop_det_o  (w_stop_det),
        .sda_sync_o  (w_sda_sync)
    );

    slave_state_t          r_state,    w_state_next;
    logic [CW-1:0]         r_bit_cnt,  w_bit_cnt_next;
    logic [DATA_WIDTH-1:0] r_shift,    w_shift_next;
    logic                  r_sda,      w_sda_next;
    logic [PW-1:0]         r_ptr,      w_ptr_next;
    i2c_op_t               r_rw,       w_rw_next;
    logic                  r_busy,     w_busy_next;
    logic                  r_start,    w_start_next;
    logic                  r_stop,     w_stop_next;
    logic                  r_wr_valid, w_wr_valid_next;
    logic [PW-1:0]         r_wr_addr,  w_wr_addr_next;
    logic                  w_store;
    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_rd_byte;

    assign w_rd_byte = w_regs[r_ptr];

    // Bus store takes priority over a host write to the same register in the same cycle.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] r_q;
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_q <= '0;
                end else if (w_store && (r_ptr == PW'(gi))) begin
                    r_q <= r_shift;
                end else if (host_we_i && (host_addr_i == PW'(gi))) begin
                    r_q <= host_wdata_i;
                end
            end
            assign w_regs[gi] = r_q;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_sda      <= 1'b1;
            r_ptr      <= '0;
            r_rw       <= WRITE;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_sda      <= w_sda_next;
            r_ptr      <= w_ptr_next;
            r_rw       <= w_rw_next;
            r_busy     <= w_busy_next;
            r_start    <= w_start_next;
            r_stop     <= w_stop_next;
            r_wr_valid <= w_wr_valid_next;
            r_wr_addr  <= w_wr_addr_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_sda_next      = r_sda;
        w_ptr_next      = r_ptr;
        w_rw_next       = r_rw;
        w_busy_next     = r_busy;
        w_start_next    = 1'b0;
        w_stop_next     = 1'b0;
        w_wr_valid_next = 1'b0;
        w_wr_addr_next  = r_wr_addr;
        w_store         = 1'b0;

        if (w_start_det) begin
            w_state_next   = ADDR;
            w_bit_cnt_next = '0;
            w_sda_next     = 1'b1;
            w_busy_next    = 1'b1;
            w_start_next   = 1'b1;
        end else if (w_stop_det) begin
            w_state_next = IDLE;
            w_sda_next   = 1'b1;
            w_busy_next  = 1'b0;
            w_stop_next  = 1'b1;
        end else begin
            if (w_scl_rise && (r_bit_cnt != FULL) &&
                ((r_state == ADDR) || (r_state == PTR) || (r_state == WDATA))) begin
                w_shift_next   = {r_shift[DATA_WIDTH-2:0], w_sda_sync};
                w_bit_cnt_next = r_bit_cnt + 1'b1;
            end

            case (r_state)
                ADDR: begin
                    if (w_scl_fall && (r_bit_cnt == FULL)) begin
                        if (r_shift[DATA_WIDTH-1 -: ADDR_WIDTH] == SLAVE_ADDR) begin
                            w_state_next = ADDR_ACK;
                            w_sda_next   = 1'b0;
                            w_rw_next    = i2c_op_t'(r_shift[0]);
                        end else begin
                            w_state_next = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_rw == WRITE) begin
                            w_state_next   = PTR;
                            w_sda_next     = 1'b1;
                            w_bit_cnt_next = '0;
                        end else begin
                            w_state_next   = RDATA;
                            w_sda_next     = w_rd_byte[DATA_WIDTH-1];
                            w_shift_next   = {w_rd_byte[DATA_WIDTH-2:0], 1'b0};
                            w_bit_cnt_next = CW'(1);
                        end
                    end
                end
                PTR: begin
                    if (w_scl_fall && (r_bit_cnt == FULL)) begin
                        w_ptr_next   = r_shift[PW-1:0];
                        w_sda_next   = 1'b0;
                        w_state_next = PTR_ACK;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_next     = 1'b1;
                        w_bit_cnt_next = '0;
                        w_state_next   = WDATA;
                    end
                end
                WDATA: begin
                    if (w_scl_fall && (r_bit_cnt == FULL)) begin
                        w_store         = 1'b1;
                        w_wr_valid_next = 1'b1;
                        w_wr_addr_next  = r_ptr;
                        w_sda_next      = 1'b0;
                        w_ptr_next      = r_ptr + 1'b1;
                        w_state_next    = WDATA_ACK;
                    end
                end
                RDATA: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == FULL) begin
                            w_sda_next     = 1'b1;
                            w_bit_cnt_next = '0;
                            w_state_next   = RDATA_ACK;
                        end else begin
                            w_sda_next     = r_shift[DATA_WIDTH-1];
                            w_shift_next   = {r_shift[DATA_WIDTH-2:0], 1'b0};
                            w_bit_cnt_next = r_bit_cnt + 1'b1;
                        end
                    end
                end
                RDATA_ACK: begin
                    // bit count 1 marks "master ACKed, next byte due on the coming fall"
                    if (w_scl_rise) begin
                        if (!w_sda_sync) begin
                            w_ptr_next     = r_ptr + 1'b1;
                            w_bit_cnt_next = CW'(1);
                        end else begin
                            w_state_next = IGNORE;
                        end
                    end else if (w_scl_fall && (r_bit_cnt == CW'(1))) begin
                        w_state_next   = RDATA;
                        w_sda_next     = w_rd_byte[DATA_WIDTH-1];
                        w_shift_next   = {w_rd_byte[DATA_WIDTH-2:0], 1'b0};
                        w_bit_cnt_next = CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_o        = r_sda;
    assign host_rdata_o = w_regs[host_addr_i];
    assign busy_o       = r_busy;
    assign start_o      = r_start;
    assign stop_o       = r_stop;
    assign wr_valid_o   = r_wr_valid;
    assign wr_addr_o    = r_wr_addr;

endmodule
